yd_regfile_p: RTL and testbench



---
 rtl/yd_regfile_p.sv | 143 ++++++++++++++
 tb/tb_yd_regfile_p.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/yd_regfile_p.sv
// Parametrised Yduck register file: two write ports, two registered-address read ports,
// auto-incrementing PC slot, DK bypass output and write-collision reporting.
// Optional feature macro: YD_REGFILE_FWD_EN enables same-cycle write forwarding on dout0/dout1.
module yd_regfile_p #(
    parameter int            DW      = 16,
    parameter int            AW      = 4,
    parameter logic [DW-1:0] PC_RST  = '0,
    parameter logic [DW-1:0] PC_STEP = 'd1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          jpc,
    input  logic [DW-1:0] din0,
    input  logic [AW-1:0] waddr0,
    input  logic          we0,
    input  logic [DW-1:0] din1,
    input  logic [AW-1:0] waddr1,
    input  logic          we1,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] dout0,
    output logic [DW-1:0] dout1,
    output logic [DW-1:0] PC,
    output logic [DW-1:0] DKD,
    output logic          wcol,
    output logic [7:0]    wcol_cnt
);

    localparam int            NS      = 1 << AW;
    localparam logic [AW-1:0] DK_ADDR = AW'(1);
    localparam logic [AW-1:0] PC_ADDR = AW'(NS - 1);

    // Slots 1 .. NS-2 (DK and RX); slot 0 and the PC live outside the array.
    logic [DW-1:0] rx_reg [1:NS-2];
    logic [DW-1:0] pc_reg;
    logic [DW-1:0] rd_vec [NS];
    logic          wcol_reg;
    logic [7:0]    wcol_cnt_reg;
    logic          collide;

    logic [AW-1:0] raddr_in  [2];
    logic [AW-1:0] raddr_reg [2];
    logic [DW-1:0] dout_vec  [2];

    assign collide = we0 && we1 && (waddr0 == waddr1) && (waddr0 != '0);

    genvar gi;
    generate
        for (gi = 1; gi < NS - 1; gi++) begin : g_slot
            localparam logic [AW-1:0] SLOT = AW'(gi);
            always_ff @(posedge clk) begin
                if (rst) begin
                    rx_reg[gi] <= '0;
                end else if (we0 && waddr0 == SLOT) begin
                    rx_reg[gi] <= din0;
                end else if (we1 && waddr1 == SLOT) begin
                    rx_reg[gi] <= din1;
                end
            end
        end
    endgenerate

    // The PC is only writable on jump cycles; otherwise it self-increments unless stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= PC_RST;
        end else if (jpc) begin
            if (we0 && waddr0 == PC_ADDR) begin
                pc_reg <= din0;
            end else if (we1 && waddr1 == PC_ADDR) begin
                pc_reg <= din1;
            end
        end else if (!stall) begin
            pc_reg <= pc_reg + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcol_reg     <= 1'b0;
            wcol_cnt_reg <= '0;
        end else begin
            wcol_reg <= collide;
            if (collide && wcol_cnt_reg != 8'hFF) begin
                wcol_cnt_reg <= wcol_cnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        rd_vec[0] = '0;
        for (int i = 1; i < NS - 1; i++) begin
            rd_vec[i] = rx_reg[i];
        end
        rd_vec[NS-1] = pc_reg;
    end

    assign raddr_in[0] = raddr0;
    assign raddr_in[1] = raddr1;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            always_ff @(posedge clk) begin
                if (rst) begin
                    raddr_reg[gi] <= '0;
                end else if (!stall) begin
                    raddr_reg[gi] <= raddr_in[gi];
                end
            end

            always_comb begin
                dout_vec[gi] = rd_vec[raddr_reg[gi]];
`ifdef YD_REGFILE_FWD_EN
                // Slot 0 never forwards; the PC slot only forwards when it is actually writable.
                if (raddr_reg[gi] != '0 && (raddr_reg[gi] != PC_ADDR || jpc)) begin
                    if (we0 && waddr0 == raddr_reg[gi]) begin
                        dout_vec[gi] = din0;
                    end else if (we1 && waddr1 == raddr_reg[gi]) begin
                        dout_vec[gi] = din1;
                    end
                end
`endif
            end
        end
    endgenerate

    always_comb begin
        DKD = rx_reg[1];
        if (we0 && waddr0 == DK_ADDR) begin
            DKD = din0;
        end else if (we1 && waddr1 == DK_ADDR) begin
            DKD = din1;
        end
    end

    assign dout0    = dout_vec[0];
    assign dout1    = dout_vec[1];
    assign PC       = pc_reg;
    assign wcol     = wcol_reg;
    assign wcol_cnt = wcol_cnt_reg;

endmodule

// File: tb/tb_yd_regfile_p.sv
// Directed scoreboard bench for yd_regfile_p (PC_RST = 0x0100); expectations adapt to YD_REGFILE_FWD_EN.
module tb_yd_regfile_p;

    logic        clk = 1'b0;
    logic        rst, stall, jpc;
    logic [15:0] din0, din1;
    logic [3:0]  waddr0, waddr1, raddr0, raddr1;
    logic        we0, we1;
    logic [15:0] dout0, dout1, PC, DKD;
    logic        wcol;
    logic [7:0]  wcol_cnt;

    always #5 clk = ~clk;

    yd_regfile_p #(
        .DW(16), .AW(4), .PC_RST(16'h0100), .PC_STEP(16'h0001)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .jpc(jpc),
        .din0(din0), .waddr0(waddr0), .we0(we0),
        .din1(din1), .waddr1(waddr1), .we1(we1),
        .raddr0(raddr0), .raddr1(raddr1),
        .dout0(dout0), .dout1(dout1), .PC(PC), .DKD(DKD),
        .wcol(wcol), .wcol_cnt(wcol_cnt)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        sb_t e;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
        $display("txn %-12s observed=%h expected=%h", e.tag, obs, e.exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; jpc = 0;
        we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; din0 = 0; din1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        raddr0 = 0; raddr1 = 0;
        rst = 1;

        // Reset state
        expect_v("rst_pc", 32'h0100); expect_v("rst_dout0", 0); expect_v("rst_dout1", 0);
        expect_v("rst_wcol", 0); expect_v("rst_cnt", 0); expect_v("rst_dkd", 0);
        step(); step();
        observe(32'(PC)); observe(32'(dout0)); observe(32'(dout1));
        observe(32'(wcol)); observe(32'(wcol_cnt)); observe(32'(DKD));

        // Three free cycles
        rst = 0;
        expect_v("pc_free3", 32'h0103); expect_v("free_dout0", 0); expect_v("free_wcol", 0);
        step(); step(); step();
        observe(32'(PC)); observe(32'(dout0)); observe(32'(wcol));

        // Collision on slot 5: port 0 wins
        we0 = 1; we1 = 1; waddr0 = 5; waddr1 = 5; din0 = 16'hAAAA; din1 = 16'h5555;
        expect_v("col_wcol", 1); expect_v("col_cnt", 1); expect_v("col_pc", 32'h0104);
        step();
        idle_inputs(); raddr0 = 5;
        observe(32'(wcol)); observe(32'(wcol_cnt)); observe(32'(PC));
        expect_v("col_wcol_drop", 0); expect_v("col_slot5", 32'hAAAA);
        step();
        observe(32'(wcol)); observe(32'(dout0));

        // Collision on slot 0 is not counted
        we0 = 1; we1 = 1; waddr0 = 0; waddr1 = 0; din0 = 16'h1111; din1 = 16'h2222;
        expect_v("col0_wcol", 0); expect_v("col0_cnt", 1);
        step();
        idle_inputs();
        observe(32'(wcol)); observe(32'(wcol_cnt));

        // Same-cycle write to the captured read address
        raddr0 = 3;
        step();
        we1 = 1; waddr1 = 3; din1 = 16'h1234;
`ifdef YD_REGFILE_FWD_EN
        expect_v("fwd_same", 32'h1234);
`else
        expect_v("fwd_same", 32'h0000);
`endif
        #1;
        observe(32'(dout0));
        expect_v("fwd_after", 32'h1234);
        step();
        idle_inputs();
        observe(32'(dout0));

        // PC write on a jump cycle, then the same write discarded without jpc
        jpc = 1; we0 = 1; waddr0 = 15; din0 = 16'h0040;
        expect_v("pc_jump_wr", 32'h0040);
        step();
        idle_inputs();
        observe(32'(PC));
        we0 = 1; waddr0 = 15; din0 = 16'h0999;
        expect_v("pc_wr_discard", 32'h0041);
        step();
        idle_inputs();
        observe(32'(PC));

        // Stall with a DK write: PC and read addresses freeze, DKD shows the live write
        stall = 1; raddr0 = 5; raddr1 = 1;
        we0 = 1; waddr0 = 1; din0 = 16'h00FF;
        expect_v("dkd_live", 32'h00FF);
        #1;
        observe(32'(DKD));
        expect_v("stall_pc", 32'h0041); expect_v("stall_dout0", 32'h1234); expect_v("stall_dout1", 0);
        step();
        we0 = 0;
        step(); step(); step();
        observe(32'(PC)); observe(32'(dout0)); observe(32'(dout1));
        stall = 0;
        expect_v("unstall_pc", 32'h0042); expect_v("unstall_dout0", 32'hAAAA);
        expect_v("dk_value", 32'h00FF); expect_v("dkd_reg", 32'h00FF);
        step();
        observe(32'(PC)); observe(32'(dout0)); observe(32'(dout1)); observe(32'(DKD));

        // 300 collision cycles saturate the counter
        we0 = 1; we1 = 1; waddr0 = 6; waddr1 = 6; din1 = 16'h0F0F;
        for (int i = 0; i < 300; i++) begin
            din0 = 16'(i);
            step();
        end
        expect_v("sat_cnt", 255); expect_v("sat_wcol", 1);
        observe(32'(wcol_cnt)); observe(32'(wcol));

        // Reset mid-sequence overrides writes, jpc and stall
        rst = 1; jpc = 1; stall = 1;
        expect_v("mrst_pc", 32'h0100); expect_v("mrst_cnt", 0); expect_v("mrst_wcol", 0);
        expect_v("mrst_dout0", 0); expect_v("mrst_dout1", 0);
        step();
        idle_inputs();
        observe(32'(PC)); observe(32'(wcol_cnt)); observe(32'(wcol));
        observe(32'(dout0)); observe(32'(dout1));
        rst = 0; raddr0 = 6; raddr1 = 1;
        expect_v("mrst_slot6", 0); expect_v("mrst_dk", 0); expect_v("mrst_pc_inc", 32'h0101);
        step();
        observe(32'(dout0)); observe(32'(dout1)); observe(32'(PC));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
